reg16_avalon_if: RTL and testbench

// Dual Avalon-MM slave front end for the 16-bit dual-port register (Q/Q2 pair).

---
 rtl/reg16_avalon_if.sv | 170 +++++++++++++++++
 tb/tb_reg16_avalon_if.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg16_avalon_if.sv
// Dual Avalon-MM slave front end for the 16-bit dual-port register pair (Q/Q2).
// Each port owns one register, can read both, and keeps its own write/error counters.
module reg16_avalon_port #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic             read,
  input  logic [15:0]      writedata,
  input  logic [1:0]       byteenable,
  input  logic [15:0]      own_q,
  input  logic [15:0]      other_q,
  input  logic             other_busy,
  output logic [15:0]      readdata,
  output logic             readdatavalid,
  output logic             waitrequest,
  output logic [15:0]      d,
  output logic [1:0]       strobe
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             target_busy;
  logic             read_accept;
  logic             clear_cnt;
  logic             wr_event;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   wr_sum;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] wr_next;
  logic [CNT_W-1:0] err_next;
  logic [15:0]      rd_mux;

  // A read stalls while its target register still has a strobe on the bus,
  // so the value sampled on acceptance already includes that write.
  always_comb begin
    target_busy = 1'b0;
    case (address)
      2'd0:    target_busy = |strobe;
      2'd1:    target_busy = other_busy;
      default: target_busy = 1'b0;
    endcase
  end

  assign waitrequest = read && !write && target_busy;
  assign read_accept = read && !write && !target_busy;
  assign clear_cnt   = write && (address == 2'd2);
  assign wr_event    = write && (address == 2'd0);

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      2'd0:    rd_mux = own_q;
      2'd1:    rd_mux = other_q;
      2'd2:    rd_mux = {err_cnt, wr_cnt};
      default: rd_mux = 16'h0000;
    endcase
  end

  // Bad-address writes and read+write collisions each count as one error,
  // so a collision on a bad address adds two.
  assign err_inc  = {1'b0, write && ((address == 2'd1) || (address == 2'd3))}
                  + {1'b0, write && read};
  assign err_sum  = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, err_inc};
  assign wr_sum   = {1'b0, wr_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign err_next = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
  assign wr_next  = wr_sum[CNT_W]  ? CNT_MAX : wr_sum[CNT_W-1:0];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      readdata      <= 16'h0000;
      readdatavalid <= 1'b0;
      d             <= 16'h0000;
      strobe        <= 2'b00;
      wr_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      readdatavalid <= read_accept;
      if (read_accept) begin
        readdata <= rd_mux;
      end
      strobe <= 2'b00;
      if (wr_event) begin
        d      <= writedata;
        strobe <= byteenable;
      end
      if (clear_cnt) begin
        wr_cnt  <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_event) begin
          wr_cnt <= wr_next;
        end
        err_cnt <= err_next;
      end
    end
  end

endmodule

module reg16_avalon_if #(
  parameter int CNT_W = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  s1_address,
  input  logic        s1_write,
  input  logic        s1_read,
  input  logic [15:0] s1_writedata,
  input  logic [1:0]  s1_byteenable,
  output logic [15:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic        s1_waitrequest,
  input  logic [1:0]  s2_address,
  input  logic        s2_write,
  input  logic        s2_read,
  input  logic [15:0] s2_writedata,
  input  logic [1:0]  s2_byteenable,
  output logic [15:0] s2_readdata,
  output logic        s2_readdatavalid,
  output logic        s2_waitrequest,
  output logic [15:0] D,
  output logic [15:0] D2,
  output logic [1:0]  byteenable,
  output logic [1:0]  byteenable2,
  input  logic [15:0] Q,
  input  logic [15:0] Q2
);

  reg16_avalon_port #(.CNT_W(CNT_W)) u_port1 (
    .clock         (clock),
    .resetn        (resetn),
    .address       (s1_address),
    .write         (s1_write),
    .read          (s1_read),
    .writedata     (s1_writedata),
    .byteenable    (s1_byteenable),
    .own_q         (Q),
    .other_q       (Q2),
    .other_busy    (|byteenable2),
    .readdata      (s1_readdata),
    .readdatavalid (s1_readdatavalid),
    .waitrequest   (s1_waitrequest),
    .d             (D),
    .strobe        (byteenable)
  );

  reg16_avalon_port #(.CNT_W(CNT_W)) u_port2 (
    .clock         (clock),
    .resetn        (resetn),
    .address       (s2_address),
    .write         (s2_write),
    .read          (s2_read),
    .writedata     (s2_writedata),
    .byteenable    (s2_byteenable),
    .own_q         (Q2),
    .other_q       (Q),
    .other_busy    (|byteenable),
    .readdata      (s2_readdata),
    .readdatavalid (s2_readdatavalid),
    .waitrequest   (s2_waitrequest),
    .d             (D2),
    .strobe        (byteenable2)
  );

endmodule

// File: tb/tb_reg16_avalon_if.sv
// Bench for reg16_avalon_if: directed scenarios plus random traffic scored
// against a transaction-level model of both registers and their counters.
module tb_reg16_avalon_if;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  s1_address, s2_address;
  logic        s1_write, s1_read, s2_write, s2_read;
  logic [15:0] s1_writedata, s2_writedata;
  logic [1:0]  s1_byteenable, s2_byteenable;
  logic [15:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;
  logic [15:0] D, D2;
  logic [1:0]  byteenable, byteenable2;
  logic [15:0] Q = 16'h0000;
  logic [15:0] Q2 = 16'h0000;

  int checks = 0;
  int fails  = 0;

  // stimulus for the current cycle, index 0 = port 1, 1 = port 2
  logic [1:0]  sAddr[2];
  logic        sWr[2];
  logic        sRd[2];
  logic [15:0] sData[2];
  logic [1:0]  sBe[2];

  // reference model state
  logic [15:0] mreg[2];
  int          mwr[2];
  int          mer[2];
  bit          busy[2];
  logic [15:0] expD[2];
  logic [1:0]  expBe[2];
  bit          expValid[2];
  logic [15:0] expData[2];
  bit          stalled[2];
  logic        obsWait[2];

  reg16_avalon_if dut (
    .clock            (clock),
    .resetn           (resetn),
    .s1_address       (s1_address),
    .s1_write         (s1_write),
    .s1_read          (s1_read),
    .s1_writedata     (s1_writedata),
    .s1_byteenable    (s1_byteenable),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_write         (s2_write),
    .s2_read          (s2_read),
    .s2_writedata     (s2_writedata),
    .s2_byteenable    (s2_byteenable),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .s2_waitrequest   (s2_waitrequest),
    .D                (D),
    .D2               (D2),
    .byteenable       (byteenable),
    .byteenable2      (byteenable2),
    .Q                (Q),
    .Q2               (Q2)
  );

  always #5 clock = ~clock;

  // external dual-port register with per-byte write strobes
  always @(posedge clock) begin
    if (byteenable[0])  Q[7:0]   <= D[7:0];
    if (byteenable[1])  Q[15:8]  <= D[15:8];
    if (byteenable2[0]) Q2[7:0]  <= D2[7:0];
    if (byteenable2[1]) Q2[15:8] <= D2[15:8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setPort(input int p, input logic wr, input logic rd, input logic [1:0] addr,
                         input logic [15:0] data, input logic [1:0] be);
    sWr[p] = wr; sRd[p] = rd; sAddr[p] = addr; sData[p] = data; sBe[p] = be;
  endtask

  task automatic setIdle();
    setPort(0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00);
    setPort(1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'b00);
  endtask

  task automatic drivePins();
    s1_address = sAddr[0]; s1_write = sWr[0]; s1_read = sRd[0];
    s1_writedata = sData[0]; s1_byteenable = sBe[0];
    s2_address = sAddr[1]; s2_write = sWr[1]; s2_read = sRd[1];
    s2_writedata = sData[1]; s2_byteenable = sBe[1];
  endtask

  function automatic int satAdd(input int v, input int n);
    return (v + n > 255) ? 255 : v + n;
  endfunction

  // One bus cycle: drive at posedge+1, predict with the model, check after the next edge.
  task automatic applyStimulus();
    logic [15:0] snapQ[2];
    bit          st[2];
    string       pn;
    int          tgt;
    int          nerr;
    drivePins();
    #1;
    snapQ[0] = mreg[0];
    snapQ[1] = mreg[1];
    for (int p = 0; p < 2; p++) begin
      pn  = (p == 0) ? "s1" : "s2";
      tgt = (sAddr[p] == 2'd0) ? p : 1 - p;
      st[p] = sRd[p] && !sWr[p] && (sAddr[p] < 2'd2) && busy[tgt];
      obsWait[p] = (p == 0) ? s1_waitrequest : s2_waitrequest;
      checkOutput({pn, "_waitrequest"}, obsWait[p], st[p]);
      expValid[p] = sRd[p] && !sWr[p] && !st[p];
      if (expValid[p]) begin
        case (sAddr[p])
          2'd0:    expData[p] = mreg[p];
          2'd1:    expData[p] = mreg[1 - p];
          2'd2:    expData[p] = {8'(mer[p]), 8'(mwr[p])};
          default: expData[p] = 16'h0000;
        endcase
      end
    end
    for (int p = 0; p < 2; p++) begin
      expBe[p] = 2'b00;
      busy[p]  = 1'b0;
      if (sWr[p]) begin
        nerr = 0;
        if (sAddr[p] == 2'd1 || sAddr[p] == 2'd3) nerr++;
        if (sRd[p]) nerr++;
        mer[p] = satAdd(mer[p], nerr);
        if (sAddr[p] == 2'd0) begin
          if (sBe[p][0]) mreg[p][7:0]  = sData[p][7:0];
          if (sBe[p][1]) mreg[p][15:8] = sData[p][15:8];
          mwr[p]   = satAdd(mwr[p], 1);
          expD[p]  = sData[p];
          expBe[p] = sBe[p];
          busy[p]  = (sBe[p] != 2'b00);
        end
        if (sAddr[p] == 2'd2) begin
          mwr[p] = 0;
          mer[p] = 0;
        end
      end
    end
    stalled[0] = st[0];
    stalled[1] = st[1];
    @(posedge clock);
    #1;
    checkOutput("s1_readdatavalid", s1_readdatavalid, expValid[0]);
    checkOutput("s2_readdatavalid", s2_readdatavalid, expValid[1]);
    if (expValid[0]) checkOutput("s1_readdata", s1_readdata, expData[0]);
    if (expValid[1]) checkOutput("s2_readdata", s2_readdata, expData[1]);
    checkOutput("byteenable", byteenable, expBe[0]);
    checkOutput("byteenable2", byteenable2, expBe[1]);
    checkOutput("D", D, expD[0]);
    checkOutput("D2", D2, expD[1]);
    checkOutput("Q", Q, snapQ[0]);
    checkOutput("Q2", Q2, snapQ[1]);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      mreg[p] = 16'h0000; mwr[p] = 0; mer[p] = 0; busy[p] = 1'b0;
      expD[p] = 16'h0000; expBe[p] = 2'b00; stalled[p] = 1'b0;
    end

    // reset held with random traffic on both ports
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 2; p++)
        setPort(p, 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 2'($urandom));
      drivePins();
      @(posedge clock);
      #1;
      checkOutput("rst_D", D, 16'h0000);
      checkOutput("rst_D2", D2, 16'h0000);
      checkOutput("rst_be", byteenable, 2'b00);
      checkOutput("rst_be2", byteenable2, 2'b00);
      checkOutput("rst_s1_rdv", s1_readdatavalid, 1'b0);
      checkOutput("rst_s2_rdv", s2_readdatavalid, 1'b0);
      checkOutput("rst_s1_rd", s1_readdata, 16'h0000);
      checkOutput("rst_s2_rd", s2_readdata, 16'h0000);
    end
    resetn = 1'b1;
    setPort(0, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00);
    setPort(1, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00);
    applyStimulus();
    checkOutput("rst_s1_status", s1_readdata, 16'h0000);
    checkOutput("rst_s2_status", s2_readdata, 16'h0000);

    // write then read back on port 1
    setIdle(); setPort(0, 1'b1, 1'b0, 2'd0, 16'hA55A, 2'b11);
    applyStimulus();
    checkOutput("wr_be_pulse", byteenable, 2'b11);
    checkOutput("wr_D", D, 16'hA55A);
    setIdle(); applyStimulus();
    checkOutput("wr_be_drop", byteenable, 2'b00);
    applyStimulus();
    setPort(0, 1'b0, 1'b1, 2'd0, 16'h0000, 2'b00);
    applyStimulus();
    checkOutput("rd_back", s1_readdata, 16'hA55A);

    // cross-port stall: s2 reads Q right after s1 writes it
    setIdle(); setPort(0, 1'b1, 1'b0, 2'd0, 16'h1234, 2'b11);
    applyStimulus();
    setIdle(); setPort(1, 1'b0, 1'b1, 2'd1, 16'h0000, 2'b00);
    applyStimulus();
    checkOutput("xport_stall", obsWait[1], 1'b1);
    applyStimulus();
    checkOutput("xport_accept", obsWait[1], 1'b0);
    checkOutput("xport_data", s2_readdata, 16'h1234);

    // byte lanes on Q2
    setIdle(); setPort(1, 1'b1, 1'b0, 2'd0, 16'hFFEE, 2'b01);
    applyStimulus();
    setIdle(); applyStimulus();
    checkOutput("lane_lo", Q2, 16'h00EE);
    setPort(1, 1'b1, 1'b0, 2'd0, 16'h7700, 2'b10);
    applyStimulus();
    setIdle(); applyStimulus();
    checkOutput("lane_hi", Q2, 16'h77EE);

    // error counting and clear on port 1
    setIdle(); setPort(0, 1'b1, 1'b0, 2'd2, 16'h0000, 2'b00); applyStimulus();
    setPort(0, 1'b1, 1'b0, 2'd1, 16'h5555, 2'b11); applyStimulus();
    setPort(0, 1'b1, 1'b0, 2'd1, 16'h6666, 2'b11); applyStimulus();
    setPort(0, 1'b1, 1'b0, 2'd3, 16'h7777, 2'b11); applyStimulus();
    setPort(0, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00); applyStimulus();
    checkOutput("err_status", s1_readdata, 16'h0300);
    setPort(0, 1'b1, 1'b0, 2'd2, 16'h0000, 2'b01); applyStimulus();
    setPort(0, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00); applyStimulus();
    checkOutput("clr_status", s1_readdata, 16'h0000);

    // write counter saturation on port 2
    setIdle();
    for (int i = 0; i < 300; i++) begin
      setPort(1, 1'b1, 1'b0, 2'd0, 16'($urandom), 2'($urandom));
      applyStimulus();
    end
    setPort(1, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00);
    applyStimulus();
    checkOutput("wr_saturate", s2_readdata, 16'h00FF);

    // simultaneous read and write on port 1
    setIdle(); setPort(0, 1'b1, 1'b0, 2'd2, 16'h0000, 2'b00); applyStimulus();
    setPort(0, 1'b1, 1'b1, 2'd0, 16'hBEEF, 2'b11); applyStimulus();
    checkOutput("rw_no_rdv", s1_readdatavalid, 1'b0);
    setIdle(); applyStimulus();
    checkOutput("rw_lands", Q, 16'hBEEF);
    setPort(0, 1'b0, 1'b1, 2'd2, 16'h0000, 2'b00); applyStimulus();
    checkOutput("rw_status", s1_readdata, 16'h0101);

    // random traffic; a stalled read holds its request until accepted
    setIdle();
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!stalled[p]) begin
          case ($urandom_range(0, 2))
            0:       setPort(p, 1'b0, 1'b0, 2'($urandom), 16'($urandom), 2'($urandom));
            1:       setPort(p, 1'b1, 1'b0, 2'($urandom_range(0, 9) < 7 ? 0 : $urandom), 16'($urandom), 2'($urandom));
            default: setPort(p, 1'b0, 1'b1, 2'($urandom), 16'($urandom), 2'($urandom));
          endcase
        end
      end
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
